// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM fetch arbiter.
// Owner tags travel down the in-flight pipeline alongside each ROM read.
package rom_fetch_arbiter_pkg;

    localparam logic MASTER_FETCH = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic owner;
    } owner_tag_t;

    // Drop a fetch-owned tag while a redirect is in progress.
    function automatic owner_tag_t kill_fetch(owner_tag_t t, logic flush);
        owner_tag_t r;
        r = t;
        if (flush && (t.owner == MASTER_FETCH)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_owner_pipe.sv
// In-flight owner tracker: fixed-depth shift register of owner tags.
// Fetch-owned entries are killed on flush; master-1 entries pass through.
module rom_owner_pipe
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  owner_tag_t push_i,
    input  logic       flush_i,
    output owner_tag_t tail_o
);

    owner_tag_t stage_q [DEPTH];
    owner_tag_t stage_d [DEPTH];

    // Next state: shift by one, applying the fetch kill at every stage.
    always_comb begin
        stage_d[0] = kill_fetch(push_i, flush_i);
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = kill_fetch(stage_q[i-1], flush_i);
        end
    end

    // Pipeline advances every cycle; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Two-master arbiter for the shared instruction ROM, one read per cycle.
// Define ROM_ARB_RR_EN for round-robin; default is fixed m0-over-m1 priority.
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    input  logic              flush_i,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    if (ROM_LATENCY < ROM_LAT_MIN || ROM_LATENCY > ROM_LAT_MAX) begin : g_bad_latency
        $error("rom_fetch_arbiter: ROM_LATENCY must be 1..4");
    end

    owner_tag_t push;
    owner_tag_t tail;

`ifdef ROM_ARB_RR_EN
    logic last_winner_q;
    logic last_winner_d;

    // Contended cycles go to the master that did not win last time.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                m0_gnt_o = (last_winner_q == MASTER_DATA);
                m1_gnt_o = (last_winner_q == MASTER_FETCH);
            end else begin
                m0_gnt_o = m0_req_i;
                m1_gnt_o = m1_req_i;
            end
        end
        last_winner_d = last_winner_q;
        if (m0_gnt_o) begin
            last_winner_d = MASTER_FETCH;
        end else if (m1_gnt_o) begin
            last_winner_d = MASTER_DATA;
        end
    end

    // Reset favours the fetch port on the first contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= MASTER_DATA;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`else
    // Fixed priority: the fetch port always wins contention.
    always_comb begin
        m0_gnt_o = m0_req_i & ~rst;
        m1_gnt_o = m1_req_i & ~m0_req_i & ~rst;
    end
`endif

    // ROM strobe and address follow the single winner; idle drives zero.
    always_comb begin
        rom_en_o   = m0_gnt_o | m1_gnt_o;
        rom_addr_o = '0;
        if (m0_gnt_o) begin
            rom_addr_o = m0_addr_i;
        end else if (m1_gnt_o) begin
            rom_addr_o = m1_addr_i;
        end
        push.valid = rom_en_o;
        push.owner = m1_gnt_o ? MASTER_DATA : MASTER_FETCH;
    end

    rom_owner_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_owner_pipe (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .flush_i (flush_i),
        .tail_o  (tail)
    );

    // Steer returning ROM data to the owner; the other port sees zero.
    always_comb begin
        m0_rvalid_o = tail.valid & (tail.owner == MASTER_FETCH);
        m1_rvalid_o = tail.valid & (tail.owner == MASTER_DATA);
        m0_rdata_o  = m0_rvalid_o ? rom_data_i : '0;
        m1_rdata_o  = m1_rvalid_o ? rom_data_i : '0;
    end

endmodule
